// File: rtl/rvga_ddr_arbiter_pkg.sv
// rtl/rvga_ddr_arbiter_pkg.sv - types and helpers for the DDR port arbiter

package rvga_ddr_arbiter_pkg;

`include "rvga_types.svh"

    // Channel index width; a single channel still carries a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rvga_arb_picker.sv
// rtl/rvga_arb_picker.sv - combinational channel picker, search starts at ptr_i

module rvga_arb_picker #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic              valid_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [IDX_W-1:0] cand;

    // Walk candidates from the farthest offset back to ptr_i so the nearest requester wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_CH);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/rvga_types.svh
// rtl/rvga_types.svh - shared rvga word, cacheline and DDR arbiter state types

typedef logic [31:0]  rvga_word;
typedef logic [255:0] rvga_cacheline;

typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
} rvga_ddr_arb_state_e;

// File: rtl/rvga_ddr_arbiter.sv
// rtl/rvga_ddr_arbiter.sv - shares one DDR port between L1 channels (macro RVGA_DDR_ARB_RR_EN selects round-robin)

module rvga_ddr_arbiter
    import rvga_ddr_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*ADDR_W-1:0] l1_arb_addr,
    input  logic [NUM_CH-1:0]        l1_arb_read,
    input  logic [NUM_CH-1:0]        l1_arb_write,
    input  logic [NUM_CH*LINE_W-1:0] l1_arb_wdata,
    output logic [LINE_W-1:0]        arb_l1_rdata,
    output logic [NUM_CH-1:0]        arb_l1_resp,
    output logic [ADDR_W-1:0]        arb_ddr_addr,
    output logic                     arb_ddr_read,
    output logic                     arb_ddr_write,
    output logic [LINE_W-1:0]        arb_ddr_wdata,
    input  logic [LINE_W-1:0]        ddr_arb_rdata,
    input  logic                     ddr_arb_resp
);

    localparam int IDX_W = idx_width(NUM_CH);

    rvga_ddr_arb_state_e state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic                ddr_read_q;
    logic                ddr_write_q;

    logic [NUM_CH-1:0]   req;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    ptr;

    assign req = l1_arb_read | l1_arb_write;

    rvga_arb_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (ptr),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef RVGA_DDR_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Next search start is the slot just after the channel being granted.
    always_comb begin
        ptr_d = (pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
    end

    // Pointer advances on every grant, including grants later abandoned by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (state_q == ARB_IDLE && pick_valid) begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    // Fixed priority: always search from channel 0.
    assign ptr = '0;
`endif

    // Two-state grant FSM; DDR request lines are registered and frozen while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ddr_read_q  <= 1'b0;
            ddr_write_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        idx_q       <= pick_idx;
                        addr_q      <= l1_arb_addr[pick_idx*ADDR_W +: ADDR_W];
                        wdata_q     <= l1_arb_wdata[pick_idx*LINE_W +: LINE_W];
                        ddr_write_q <= l1_arb_write[pick_idx];
                        ddr_read_q  <= ~l1_arb_write[pick_idx];
                        state_q     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (ddr_arb_resp) begin
                        ddr_read_q  <= 1'b0;
                        ddr_write_q <= 1'b0;
                        state_q     <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // Completion is steered to the granted channel in the same cycle DDR answers.
    always_comb begin
        arb_l1_resp = '0;
        if (state_q == ARB_BUSY && ddr_arb_resp) begin
            arb_l1_resp[idx_q] = 1'b1;
        end
    end

    assign arb_l1_rdata  = ddr_arb_rdata;
    assign arb_ddr_addr  = addr_q;
    assign arb_ddr_wdata = wdata_q;
    assign arb_ddr_read  = ddr_read_q;
    assign arb_ddr_write = ddr_write_q;

endmodule

// File: tb/tb_rvga_ddr_arbiter.sv
// tb/tb_rvga_ddr_arbiter.sv - scoreboard bench for the DDR port arbiter

module tb_rvga_ddr_arbiter;

    localparam int NCH = 4;

    typedef struct {
        int           ch;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NCH*32-1:0]  l1_addr  = '0;
    logic [NCH-1:0]     l1_read  = '0;
    logic [NCH-1:0]     l1_write = '0;
    logic [NCH*256-1:0] l1_wdata = '0;
    logic [255:0]       arb_l1_rdata;
    logic [NCH-1:0]     arb_l1_resp;
    logic [31:0]        arb_ddr_addr;
    logic               arb_ddr_read;
    logic               arb_ddr_write;
    logic [255:0]       arb_ddr_wdata;
    logic [255:0]       ddr_rdata = '0;
    logic               ddr_resp  = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_ptr    = 0;
    exp_t sb[$];

    rvga_ddr_arbiter #(
        .NUM_CH (NCH),
        .ADDR_W (32),
        .LINE_W (256)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .l1_arb_addr   (l1_addr),
        .l1_arb_read   (l1_read),
        .l1_arb_write  (l1_write),
        .l1_arb_wdata  (l1_wdata),
        .arb_l1_rdata  (arb_l1_rdata),
        .arb_l1_resp   (arb_l1_resp),
        .arb_ddr_addr  (arb_ddr_addr),
        .arb_ddr_read  (arb_ddr_read),
        .arb_ddr_write (arb_ddr_write),
        .arb_ddr_wdata (arb_ddr_wdata),
        .ddr_arb_rdata (ddr_rdata),
        .ddr_arb_resp  (ddr_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick(input logic [NCH-1:0] r, input int p);
        logic [1:0] j;
        for (int k = 0; k < NCH; k++) begin
            j = 2'((p + k) % NCH);
            if (r[j]) return int'(j);
        end
        return -1;
    endfunction

    // Predict the next n grants from the current request inputs.
    task automatic push_seq(input int n, input bit drop);
        logic [NCH-1:0] r;
        exp_t e;
        int c;
        r = l1_read | l1_write;
        for (int i = 0; i < n; i++) begin
            c = model_pick(r, m_ptr);
            if (c < 0) break;
            e.ch    = c;
            e.wr    = l1_write[2'(c)];
            e.addr  = l1_addr[c*32 +: 32];
            e.wdata = l1_wdata[c*256 +: 256];
            sb.push_back(e);
            if (drop) r[2'(c)] = 1'b0;
`ifdef RVGA_DDR_ARB_RR_EN
            m_ptr = (c + 1) % NCH;
`endif
        end
    endtask

    task automatic set_ch(input int c, input bit rd, input bit wr, input logic [31:0] a);
        l1_read[2'(c)]       = rd;
        l1_write[2'(c)]      = wr;
        l1_addr[c*32 +: 32]  = a;
        l1_wdata[c*256 +: 256] = {8{32'hC0DE_0000 + a}};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_ptr = 0;
    endtask

    // Act as the DDR side for one transaction and compare against the scoreboard.
    task automatic serve(input int lat, input logic [255:0] rd, input bit drop,
                         input bit chg, input logic [31:0] chg_addr);
        exp_t e;
        int waited;
        waited = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arb_ddr_read || arb_ddr_write) begin
                waited = i;
                break;
            end
        end
        if (waited < 0) begin
            check("ddr_req_seen", 0, 1);
            return;
        end
        check("req_latency", waited, 0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("ddr_addr", arb_ddr_addr, e.addr);
        check("ddr_write", arb_ddr_write, e.wr);
        check("ddr_read", arb_ddr_read, !e.wr);
        if (e.wr) check("ddr_wdata", arb_ddr_wdata, e.wdata);
        if (drop) begin
            l1_read[2'(e.ch)]  = 1'b0;
            l1_write[2'(e.ch)] = 1'b0;
        end
        if (chg) l1_addr[e.ch*32 +: 32] = chg_addr;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("hold_addr", arb_ddr_addr, e.addr);
            check("resp_quiet", arb_l1_resp, 0);
        end
        ddr_rdata = rd;
        ddr_resp  = 1'b1;
        #1;
        check("l1_resp", arb_l1_resp, 4'b0001 << e.ch);
        check("l1_rdata", arb_l1_rdata, rd);
        @(negedge clk);
        ddr_resp = 1'b0;
        #1;
        check("gap_idle", {arb_ddr_read, arb_ddr_write}, 0);
        check("resp_clear", arb_l1_resp, 0);
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_read", arb_ddr_read, 0);
        check("rst_write", arb_ddr_write, 0);
        check("rst_addr", arb_ddr_addr, 0);
        check("rst_wdata", arb_ddr_wdata, 0);
        check("rst_resp", arb_l1_resp, 0);
        do_reset();

        // Single read on ch0, response after 5 cycles.
        @(negedge clk);
        set_ch(0, 1, 0, 32'h0000_1000);
        push_seq(1, 1);
        #1;
        check("no_comb_req", arb_ddr_read, 0);
        serve(5, {32{8'hA5}}, 1, 0, 0);

        // Simultaneous ch0 read and ch1 write from pointer 0.
        do_reset();
        @(negedge clk);
        set_ch(0, 1, 0, 32'h100);
        set_ch(1, 0, 1, 32'h200);
        push_seq(2, 1);
        serve(2, {8{32'h1111_0000}}, 1, 0, 0);
        serve(3, {8{32'h2222_0000}}, 1, 0, 0);

        // All four channels requesting continuously.
        do_reset();
        @(negedge clk);
        for (int c = 0; c < NCH; c++) set_ch(c, (c % 2) == 0, (c % 2) == 1, 32'h1000 * c + 32'h40);
        push_seq(5, 0);
        for (int k = 0; k < 5; k++) serve(1 + k, {8{32'h3300_0000 + k}}, 0, 0, 0);
        l1_read  = '0;
        l1_write = '0;
        sb.delete();
        m_ptr = 0;
        do_reset();

        // Address change mid-transaction must not reach DDR.
        @(negedge clk);
        set_ch(1, 0, 1, 32'h300);
        push_seq(1, 0);
        serve(4, {8{32'h4444_0000}}, 0, 1, 32'h400);
        l1_write = '0;
        do_reset();

        // Read and write together is a write.
        @(negedge clk);
        set_ch(0, 1, 1, 32'h500);
        push_seq(1, 1);
        serve(2, {8{32'h5555_0000}}, 1, 0, 0);

        // Reset two cycles into a read.
        do_reset();
        @(negedge clk);
        set_ch(0, 1, 0, 32'h600);
        @(negedge clk);
        check("mid_busy_read", arb_ddr_read, 1);
        @(negedge clk);
        ddr_resp = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_mid_read", arb_ddr_read, 0);
        check("rst_mid_addr", arb_ddr_addr, 0);
        check("rst_mid_resp", arb_l1_resp, 0);
        l1_read = '0;
        sb.delete();
        m_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_resp_ignored", arb_l1_resp, 0);
            check("idle_no_req", {arb_ddr_read, arb_ddr_write}, 0);
        end
        ddr_resp = 1'b0;
        @(negedge clk);
        set_ch(0, 1, 0, 32'h700);
        set_ch(1, 0, 1, 32'h800);
        push_seq(2, 1);
        serve(1, {8{32'h7777_0000}}, 1, 0, 0);
        serve(1, {8{32'h8888_0000}}, 1, 0, 0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rvga_ddr_arbiter.md
RVGA_DDR_ARBITER -- requirements
Module: rvga_ddr_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of L1 cache channels sharing one DDR port (legal range 1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-003 SHALL have parameter LINE_W, default 256, cacheline width in bits.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port l1_arb_addr, input, NUM_CH x ADDR_W, per-channel line address.
REQ-007 SHALL have port l1_arb_read, input, NUM_CH, per-channel read request.
REQ-008 SHALL have port l1_arb_write, input, NUM_CH, per-channel write request.
REQ-009 SHALL have port l1_arb_wdata, input, NUM_CH x LINE_W, per-channel write line.
REQ-010 SHALL have port arb_l1_rdata, output, LINE_W, read line broadcast to all channels.
REQ-011 SHALL have port arb_l1_resp, output, NUM_CH, one-hot per-channel completion.
REQ-012 SHALL have ports arb_ddr_addr (output, ADDR_W), arb_ddr_read (output, 1), arb_ddr_write (output, 1), arb_ddr_wdata (output, LINE_W): DDR request side.
REQ-013 SHALL have ports ddr_arb_rdata (input, LINE_W) and ddr_arb_resp (input, 1): DDR completion side.

Function
REQ-014 SHALL implement states IDLE and BUSY only.
REQ-015 In IDLE, when any channel asserts read or write, SHALL select one channel per REQ-026/027, latch its addr, wdata, op and index, and enter BUSY next edge.
REQ-016 SHALL assert arb_ddr_read or arb_ddr_write from registers only in BUSY, so DDR request starts exactly 1 cycle after the request is seen in IDLE.
REQ-017 SHALL hold arb_ddr_addr/wdata/read/write constant throughout BUSY regardless of channel input changes.
REQ-018 In BUSY, when ddr_arb_resp=1, SHALL drive arb_l1_resp[granted]=1 combinationally in that same cycle, pass ddr_arb_rdata to arb_l1_rdata, and return to IDLE next edge.
REQ-019 SHALL assert at most one arb_l1_resp bit in any cycle, and none outside BUSY.
REQ-020 A channel asserting read and write together SHALL be serviced as a write.
REQ-021 SHALL ignore ddr_arb_resp in IDLE.
REQ-022 SHALL guarantee one IDLE cycle between consecutive DDR transactions (no back-to-back grant).
REQ-023 NUM_CH=1 SHALL behave as a registered pass-through with the same 1-cycle request latency.

Reset
REQ-024 On rst=1, immediately and asynchronously: state=IDLE, arb_ddr_read=0, arb_ddr_write=0, arb_ddr_addr=0, arb_ddr_wdata=0, arb_l1_resp=0, round-robin pointer=0.
REQ-025 Reset during BUSY SHALL abandon the transaction without issuing arb_l1_resp; the DDR side sees read/write drop.

Configuration
REQ-026 With macro RVGA_DDR_ARB_RR_EN defined, SHALL use round-robin: the search starts at pointer; after each grant the pointer = granted index+1 mod NUM_CH.
REQ-027 Without RVGA_DDR_ARB_RR_EN, SHALL use fixed priority, lowest index wins; no pointer register exists.

Structure
REQ-028 The state enum rvga_ddr_arb_state_e SHALL live in rvga_types.svh beside rvga_word/rvga_cacheline.
REQ-029 Channel selection SHALL be a combinational sub-module rvga_arb_picker (inputs: request vector, pointer; outputs: valid, index of width max(1,$clog2(NUM_CH))).

Verification
REQ-030 Single read: ch0 read addr 0x0000_1000, DDR resp after 5 cycles with rdata 0xA5..A5 -> arb_ddr_read rises 1 cycle after the request, arb_l1_resp=2'b01 in the resp cycle, arb_l1_rdata=0xA5..A5.
REQ-031 Simultaneous: ch0 read 0x100 and ch1 write 0x200 in the same cycle (RR_EN, pointer 0) -> ch0 serviced first, then ch1 write with wdata intact; with RR_EN undefined and ch0 re-requesting, ch0 is serviced repeatedly.
REQ-032 Fairness: NUM_CH=4, all channels continuously requesting, RR_EN -> grant order 0,1,2,3,0; each transaction is separated by one IDLE cycle.
REQ-033 Hold: ch1 changes addr 0x300 to 0x400 mid-BUSY -> arb_ddr_addr stays 0x300 until resp.
REQ-034 Reset mid-BUSY: rst pulsed 2 cycles into a read -> outputs 0 that cycle, no arb_l1_resp, pointer 0, a subsequent DDR resp is ignored.
REQ-035 Read+write together on ch0 -> arb_ddr_write=1, arb_ddr_read=0.
